// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store select encodings, FSM states and counter sizing for lsu_mem_ctrl
package lsu_pkg;

    localparam logic [2:0] L_LB  = 3'b001;
    localparam logic [2:0] L_LH  = 3'b010;
    localparam logic [2:0] L_LBU = 3'b011;
    localparam logic [2:0] L_LHU = 3'b100;
    localparam logic [2:0] L_LW  = 3'b101;

    localparam logic [1:0] S_SB = 2'b01;
    localparam logic [1:0] S_SH = 2'b10;
    localparam logic [1:0] S_SW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR
    } lsu_state_e;

    // Counter only has to reach TIMEOUT-1 before the abort decision.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering / byte enables and load extract / extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_sel_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    input  logic [2:0]  ld_sel_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata_o = '0;
        st_be_o    = '0;
        case (st_sel_i)
            S_SB: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_be_o    = 4'b0001 << st_off_i;
            end
            S_SH: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            S_SW: begin
                st_wdata_o = st_data_i;
                st_be_o    = 4'b1111;
            end
            default: ;
        endcase
    end

    assign ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = '0;
        case (ld_sel_i)
            L_LB:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            L_LH:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            L_LBU:   ld_data_o = {24'd0, ld_byte};
            L_LHU:   ld_data_o = {16'd0, ld_half};
            L_LW:    ld_data_o = ld_rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit driving a word-organised data memory over req/ack
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_rden,
    input  logic              i_mem_wren,
    input  logic [2:0]        i_l_sel,
    input  logic [1:0]        i_s_sel,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_st_data,
    output logic [31:0]       o_ld_data,
    output logic              o_done,
    output logic              o_stall,
    output logic              o_fault,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [31:0]       o_bus_wdata,
    output logic [3:0]        o_bus_be,
    input  logic              i_bus_ack,
    input  logic [31:0]       i_bus_rdata
);

    localparam int CW = cnt_width(TIMEOUT);

    lsu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [2:0]        l_sel_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       ld_data_q;

    logic        ld_ok, ld_mis, st_ok, st_mis, bad_c, is_idle, go_c;
    logic [31:0] st_wdata, ld_ext;
    logic [3:0]  st_be;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

    assign ld_ok  = i_l_sel inside {L_LB, L_LH, L_LBU, L_LHU, L_LW};
    assign ld_mis = ((i_l_sel == L_LH || i_l_sel == L_LHU) && i_addr[0])
                  || (i_l_sel == L_LW && i_addr[1:0] != 2'b00);
    assign st_ok  = i_s_sel != 2'b00;
    assign st_mis = (i_s_sel == S_SH && i_addr[0])
                  || (i_s_sel == S_SW && i_addr[1:0] != 2'b00);
    assign bad_c  = (i_mem_rden && i_mem_wren)
                  || (i_mem_rden && (!ld_ok || ld_mis))
                  || (i_mem_wren && (!st_ok || st_mis));

    assign is_idle = (state_q == ST_IDLE);
    assign go_c    = is_idle && (i_mem_rden ^ i_mem_wren) && !bad_c;

    lsu_align u_align (
        .st_sel_i   (i_s_sel),
        .st_off_i   (i_addr[1:0]),
        .st_data_i  (i_st_data),
        .st_wdata_o (st_wdata),
        .st_be_o    (st_be),
        .ld_sel_i   (l_sel_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (i_bus_rdata),
        .ld_data_o  (ld_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            off_q     <= '0;
            l_sel_q   <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            ld_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (go_c) begin
                        state_q <= ST_REQ;
                        addr_q  <= i_addr[ADDR_W+1:2];
                        off_q   <= i_addr[1:0];
                        l_sel_q <= i_l_sel;
                        we_q    <= i_mem_wren;
                        wdata_q <= i_mem_wren ? st_wdata : 32'd0;
                        be_q    <= i_mem_wren ? st_be : 4'd0;
                    end
                end
                ST_REQ: begin
                    // Bus-side registers clear on leaving REQ so they read 0 elsewhere.
                    if (i_bus_ack || cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= i_bus_ack ? ST_DONE : ST_ERR;
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        be_q    <= '0;
                        cnt_q   <= '0;
                        if (i_bus_ack) begin
                            ld_data_q <= we_q ? 32'd0 : ld_ext;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall/fault have a combinational IDLE term, so gate them with reset too.
    assign o_stall     = i_rst_n && (state_q == ST_REQ || go_c);
    assign o_fault     = i_rst_n && (state_q == ST_ERR
                       || (is_idle && (i_mem_rden || i_mem_wren) && bad_c));
    assign o_done      = (state_q == ST_DONE);
    assign o_bus_req   = (state_q == ST_REQ);
    assign o_bus_we    = we_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_bus_be    = be_q;
    assign o_ld_data   = ld_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl with directed and random accesses
module tb_lsu_mem_ctrl;

    localparam int ADDR_W = 16;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rden, wren;
    logic [2:0]        l_sel;
    logic [1:0]        s_sel;
    logic [31:0]       addr, st_data;
    logic [31:0]       ld_data;
    logic              done, stall, fault;
    logic              bus_req, bus_we, bus_ack;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata, bus_rdata;
    logic [3:0]        bus_be;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mem_rden  (rden),
        .i_mem_wren  (wren),
        .i_l_sel     (l_sel),
        .i_s_sel     (s_sel),
        .i_addr      (addr),
        .i_st_data   (st_data),
        .o_ld_data   (ld_data),
        .o_done      (done),
        .o_stall     (stall),
        .o_fault     (fault),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .o_bus_be    (bus_be),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ld_size(input logic [2:0] s);
        case (s)
            3'd1, 3'd3: return 1;
            3'd2, 3'd4: return 2;
            3'd5:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic int st_size(input logic [1:0] s);
        case (s)
            2'd1:    return 1;
            2'd2:    return 2;
            2'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a,
                                               input logic [31:0] rdata);
        int          sz;
        int          off;
        logic [63:0] v;
        sz  = ld_size(s);
        off = int'(a[1:0]);
        v   = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
        if ((s == 3'd1 || s == 3'd2) && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] d);
        if (sz == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    task automatic drop_inputs();
        rden = 1'b0; wren = 1'b0; l_sel = '0; s_sel = '0;
    endtask

    // ack_lat: REQ-cycle index carrying the ack, or -1 for no ack at all.
    task automatic access(input logic rd, input logic wr, input logic [2:0] ls,
                          input logic [1:0] ss, input logic [31:0] a, input logic [31:0] sd,
                          input int ack_lat, input logic [31:0] rdata,
                          output logic [31:0] ld_obs);
        int          lsz, ssz, be_i;
        logic        flt, acked;
        logic [31:0] e_addr;
        lsz    = ld_size(ls);
        ssz    = st_size(ss);
        flt    = (rd && wr) || (rd && (lsz == 0 || (int'(a[1:0]) % lsz) != 0))
                            || (wr && (ssz == 0 || (int'(a[1:0]) % ssz) != 0));
        e_addr = 32'(a[ADDR_W+1:2]);
        be_i   = ((1 << ssz) - 1) << int'(a[1:0]);
        ld_obs = '0;
        acked  = 1'b0;
        @(negedge clk);
        rden = rd; wren = wr; l_sel = ls; s_sel = ss; addr = a; st_data = sd; bus_ack = 1'b0;
        #1;
        if (flt) begin
            chk("fault_pulse", 32'(fault), 32'd1);
            chk("fault_no_stall", 32'(stall), 32'd0);
            chk("fault_no_req", 32'(bus_req), 32'd0);
            @(negedge clk);
            drop_inputs();
            #1;
            chk("fault_one_cycle", 32'(fault), 32'd0);
            chk("fault_still_no_req", 32'(bus_req), 32'd0);
            return;
        end
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_no_fault", 32'(fault), 32'd0);
        chk("idle_no_req_yet", 32'(bus_req), 32'd0);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            #1;
            chk("req_high", 32'(bus_req), 32'd1);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_we", 32'(bus_we), 32'(wr));
            chk("req_addr", 32'(bus_addr), e_addr);
            chk("req_be", 32'(bus_be), wr ? 32'(be_i[3:0]) : 32'd0);
            chk("req_wdata", bus_wdata, wr ? model_wdata(ssz, sd) : 32'd0);
            if (k == ack_lat) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
                acked     = 1'b1;
                break;
            end
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        #1;
        if (acked) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_no_stall", 32'(stall), 32'd0);
            chk("done_no_fault", 32'(fault), 32'd0);
            chk("done_no_req", 32'(bus_req), 32'd0);
            chk("done_ld_data", ld_data, wr ? 32'd0 : model_load(ls, a, rdata));
            ld_obs = ld_data;
        end else begin
            chk("timeout_fault", 32'(fault), 32'd1);
            chk("timeout_no_stall", 32'(stall), 32'd0);
            chk("timeout_req_dropped", 32'(bus_req), 32'd0);
            chk("timeout_no_done", 32'(done), 32'd0);
            bus_ack = 1'b1;
        end
        @(negedge clk);
        drop_inputs();
        #1;
        chk("back_idle_done", 32'(done), 32'd0);
        chk("back_idle_fault", 32'(fault), 32'd0);
        chk("back_idle_req", 32'(bus_req), 32'd0);
        chk("back_idle_stall", 32'(stall), 32'd0);
        if (!acked) begin
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
            chk("late_ack_ignored_req", 32'(bus_req), 32'd0);
            chk("late_ack_ignored_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] obs;
        logic        r_rd, r_wr;
        int          mode;

        rst_n = 1'b0; drop_inputs(); addr = '0; st_data = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #12;
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 1'b1, 3'd0, 2'b11, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'd0, obs);
        access(1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_0013, 32'd0, 0, 32'h80FF_0000, obs);
        chk("lb_sign", obs, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_0013, 32'd0, 0, 32'h80FF_0000, obs);
        chk("lbu_zero", obs, 32'h0000_0080);
        access(1'b0, 1'b1, 3'd0, 2'b10, 32'h0000_0022, 32'h1234_ABCD, 1, 32'd0, obs);
        access(1'b1, 1'b0, 3'b100, 2'b00, 32'h0000_0022, 32'd0, 0, 32'hABCD_0000, obs);
        chk("lhu_zero", obs, 32'h0000_ABCD);
        access(1'b1, 1'b0, 3'b101, 2'b00, 32'h0000_0006, 32'd0, 0, 32'd0, obs);
        access(1'b1, 1'b1, 3'b101, 2'b11, 32'h0000_0008, 32'd0, 0, 32'd0, obs);
        access(1'b1, 1'b0, 3'b110, 2'b00, 32'h0000_0008, 32'd0, 0, 32'd0, obs);
        access(1'b0, 1'b1, 3'd0, 2'b00, 32'h0000_0008, 32'd0, 0, 32'd0, obs);
        access(1'b1, 1'b0, 3'b101, 2'b00, 32'h0000_0040, 32'd0, -1, 32'd0, obs);

        @(negedge clk);
        rden = 1'b0; wren = 1'b1; s_sel = 2'b11; addr = 32'h0000_0080; st_data = 32'h5555_AAAA;
        @(negedge clk);
        #1;
        chk("pre_reset_req", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_req", 32'(bus_req), 32'd0);
        chk("async_reset_stall", 32'(stall), 32'd0);
        chk("async_reset_fault", 32'(fault), 32'd0);
        @(negedge clk);
        drop_inputs();
        rst_n = 1'b1;
        access(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_0082, 32'd0, 1, 32'h8001_7FFF, obs);
        chk("post_reset_lh", obs, 32'hFFFF_8001);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 9));
            r_rd = (mode < 5) || (mode == 9);
            r_wr = (mode >= 5);
            access(r_rd, r_wr, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom, int'($urandom_range(0, 4)) - 1 + ((i % 5 == 0) ? 0 : 1),
                   $urandom, obs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
